// File: rtl/pulse_gen_pkg.sv
// pulse_gen shared types: FSM state encoding and default counter width.
// Imported by the pulse generator top and its counter.
package pulse_gen_pkg;

  localparam int BIT_SZ_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

endpackage

// File: rtl/pulse_gen_16_if.sv
// Trigger/programming and pulse-status bundle for pulse_gen_16.
// halt exists only when PULSE_GEN_REPEAT_EN is defined.
interface pulse_gen_16_if #(
  parameter int BIT_SZ = 16
);

  logic              tick;
  logic              trigger;
  logic [BIT_SZ-1:0] delay;
  logic [BIT_SZ-1:0] width;
`ifdef PULSE_GEN_REPEAT_EN
  logic              halt;
`endif
  logic              start;
  logic              stop;
  logic              pulse;
  logic              busy;

  modport master (
    output tick, trigger, delay, width,
`ifdef PULSE_GEN_REPEAT_EN
    output halt,
`endif
    input  start, stop, pulse, busy
  );

  modport slave (
    input  tick, trigger, delay, width,
`ifdef PULSE_GEN_REPEAT_EN
    input  halt,
`endif
    output start, stop, pulse, busy
  );

endinterface

// File: rtl/tick_down_counter.sv
// Loadable down-counter gated by the time-base tick; holds at zero.
// Load wins over a tick in the same cycle.
module tick_down_counter
  import pulse_gen_pkg::*;
#(
  parameter int BIT_SZ = BIT_SZ_DEF
) (
  input  logic              sysclk,
  input  logic              sreset,
  input  logic              load,
  input  logic [BIT_SZ-1:0] load_val,
  input  logic              en,
  output logic              zero
);

  logic [BIT_SZ-1:0] r_count;

  always_ff @(posedge sysclk) begin
    if (sreset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero = (r_count == '0);

endmodule

// File: rtl/pulse_gen_16.sv
// Single-shot pulse generator with registered start/stop strobes.
// PULSE_GEN_REPEAT_EN adds halt and free-running repeat mode.
module pulse_gen_16
  import pulse_gen_pkg::*;
#(
  parameter int BIT_SZ = BIT_SZ_DEF
) (
  input logic           sysclk,
  input logic           sreset,
  pulse_gen_16_if.slave bus
);

  state_t            r_state;
  state_t            w_next;
  logic [BIT_SZ-1:0] r_width;
  logic [BIT_SZ-1:0] r_delay;
  logic [BIT_SZ-1:0] w_load_val;
  logic              w_load;
  logic              w_zero;
  logic              w_halt_pend;
  logic              r_start;
  logic              r_stop;
  logic              r_pulse;
  logic              r_busy;

  tick_down_counter #(
    .BIT_SZ (BIT_SZ)
  ) u_cnt (
    .sysclk   (sysclk),
    .sreset   (sreset),
    .load     (w_load),
    .load_val (w_load_val),
    .en       (bus.tick),
    .zero     (w_zero)
  );

`ifdef PULSE_GEN_REPEAT_EN
  logic r_halt;

  always_ff @(posedge sysclk) begin
    if (sreset) begin
      r_halt <= 1'b0;
    end else if (w_next == IDLE) begin
      r_halt <= 1'b0;
    end else if (bus.halt && (r_state != IDLE)) begin
      r_halt <= 1'b1;
    end
  end

  // a halt seen in the final ACTIVE cycle still ends the run
  assign w_halt_pend = r_halt | bus.halt;
`else
  assign w_halt_pend = 1'b1;
`endif

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    unique case (r_state)
      IDLE: begin
        if (bus.trigger) begin
          w_next     = DELAY;
          w_load     = 1'b1;
          w_load_val = bus.delay;
        end
      end
      DELAY: begin
        if (w_zero) begin
          w_next     = ACTIVE;
          w_load     = 1'b1;
          w_load_val = r_width;
        end
      end
      ACTIVE: begin
        if (w_zero) begin
          if (w_halt_pend) begin
            w_next = IDLE;
          end else begin
            w_next     = DELAY;
            w_load     = 1'b1;
            w_load_val = r_delay;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (sreset) begin
      r_state <= IDLE;
      r_width <= '0;
      r_delay <= '0;
      r_start <= 1'b0;
      r_stop  <= 1'b0;
      r_pulse <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == IDLE) && bus.trigger) begin
        r_width <= bus.width;
        r_delay <= bus.delay;
      end
      // strobes are decoded from the transition, so they align with pulse
      r_start <= (w_next == ACTIVE) && (r_state != ACTIVE);
      r_stop  <= (r_state == ACTIVE) && (w_next != ACTIVE);
      r_pulse <= (w_next == ACTIVE);
      r_busy  <= (w_next != IDLE);
    end
  end

  assign bus.start = r_start;
  assign bus.stop  = r_stop;
  assign bus.pulse = r_pulse;
  assign bus.busy  = r_busy;

endmodule

// File: tb/tb_pulse_gen_16.sv
// Directed bench for pulse_gen_16: per-run edge statistics vs hand values.
// Repeat-mode scenario is built only with PULSE_GEN_REPEAT_EN.
module tb_pulse_gen_16;

  logic sysclk;
  logic sreset;

  pulse_gen_16_if #(.BIT_SZ(16)) bus ();

  pulse_gen_16 #(
    .BIT_SZ (16)
  ) dut (
    .sysclk (sysclk),
    .sreset (sreset),
    .bus    (bus)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int n_chk;
  int n_bad;

  int n_start, first_start, last_start;
  int n_stop, first_stop, last_stop;
  int n_pulse, first_pulse, last_pulse;
  int n_busy, first_busy, last_busy;
  int n_both;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic drive_halt(input int c, input int hc);
`ifdef PULSE_GEN_REPEAT_EN
    bus.halt = (hc == 0) ? 1'b1 : (c == hc);
`else
    if (c < 0 && hc < 0) bus.tick = 1'b0;
`endif
  endtask

  task automatic record(input int c);
    if (bus.start) begin
      n_start++; last_start = c;
      if (first_start < 0) first_start = c;
    end
    if (bus.stop) begin
      n_stop++; last_stop = c;
      if (first_stop < 0) first_stop = c;
    end
    if (bus.pulse) begin
      n_pulse++; last_pulse = c;
      if (first_pulse < 0) first_pulse = c;
    end
    if (bus.busy) begin
      n_busy++; last_busy = c;
      if (first_busy < 0) first_busy = c;
    end
    if (bus.start && bus.stop) n_both++;
  endtask

  // trigger sits in cycle 0 (accepted at edge 0); cycle c follows edge c-1
  task automatic launch(input int d, input int w, input int tper,
                        input int nd, input int nw,
                        input int rt1, input int rt2,
                        input int hc, input int ncyc);
    n_start = 0; first_start = -1; last_start = -1;
    n_stop  = 0; first_stop  = -1; last_stop  = -1;
    n_pulse = 0; first_pulse = -1; last_pulse = -1;
    n_busy  = 0; first_busy  = -1; last_busy  = -1;
    n_both  = 0;
    bus.delay   = d[15:0];
    bus.width   = w[15:0];
    bus.trigger = 1'b1;
    bus.tick    = 1'b1;
    drive_halt(0, hc);
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge sysclk); #1;
      bus.trigger = (c == rt1) || (c == rt2);
      bus.tick    = (c % tper) == 0;
      bus.delay   = nd[15:0];
      bus.width   = nw[15:0];
      drive_halt(c, hc);
      record(c);
    end
    bus.trigger = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    sreset      = 1'b1;
    bus.tick    = 1'b0;
    bus.trigger = 1'b0;
    bus.delay   = '0;
    bus.width   = '0;
    drive_halt(0, 0);
    repeat (3) @(posedge sysclk);
    #1;
    chk("rst_out", {28'd0, bus.start, bus.stop, bus.pulse, bus.busy}, 32'd0);
    sreset = 1'b0;
    @(posedge sysclk); #1;
    chk("rst_idle_busy", {31'd0, bus.busy}, 32'd0);

    launch(0, 0, 1, 0, 0, 0, 0, 0, 6);
    chk("t1_start_cyc", first_start, 2);
    chk("t1_n_start", n_start, 1);
    chk("t1_stop_cyc", first_stop, 3);
    chk("t1_n_stop", n_stop, 1);
    chk("t1_pulse_cyc", first_pulse, 2);
    chk("t1_n_pulse", n_pulse, 1);
    chk("t1_busy_first", first_busy, 1);
    chk("t1_busy_last", last_busy, 2);

    launch(3, 4, 2, 3, 4, 0, 0, 0, 20);
    chk("t2_start_cyc", first_start, 8);
    chk("t2_n_start", n_start, 1);
    chk("t2_stop_cyc", first_stop, 16);
    chk("t2_n_stop", n_stop, 1);
    chk("t2_pulse_first", first_pulse, 8);
    chk("t2_pulse_last", last_pulse, 15);
    chk("t2_n_busy", n_busy, 15);

    launch(3, 4, 1, 9, 9, 2, 6, 0, 16);
    chk("t3_start_cyc", first_start, 5);
    chk("t3_n_start", n_start, 1);
    chk("t3_n_pulse", n_pulse, 5);
    chk("t3_stop_cyc", first_stop, 10);
    chk("t3_n_busy", n_busy, 9);

    bus.delay   = 16'd0;
    bus.width   = 16'd100;
    bus.trigger = 1'b1;
    bus.tick    = 1'b1;
    drive_halt(0, 0);
    @(posedge sysclk); #1;
    bus.trigger = 1'b0;
    repeat (3) @(posedge sysclk);
    #1;
    chk("t4_pre_pulse", {31'd0, bus.pulse}, 32'd1);
    sreset = 1'b1;
    @(posedge sysclk); #1;
    chk("t4_rst_out", {28'd0, bus.start, bus.stop, bus.pulse, bus.busy}, 32'd0);
    sreset = 1'b0;
    @(posedge sysclk); #1;
    chk("t4_no_stop", {30'd0, bus.stop, bus.busy}, 32'd0);
    launch(1, 2, 1, 1, 2, 0, 0, 0, 10);
    chk("t4_re_start", first_start, 3);
    chk("t4_re_stop", first_stop, 6);
    chk("t4_re_n_pulse", n_pulse, 3);

    launch(0, 0, 1, 0, 0, 3, 0, 0, 10);
    chk("t5_n_start", n_start, 2);
    chk("t5_start2_cyc", last_start, 5);
    chk("t5_n_stop", n_stop, 2);
    chk("t5_stop2_cyc", last_stop, 6);
    chk("t5_overlap", n_both, 0);
    chk("t5_n_busy", n_busy, 4);

`ifdef PULSE_GEN_REPEAT_EN
    launch(2, 1, 1, 2, 1, 0, 0, 14, 20);
    chk("rp_n_start", n_start, 3);
    chk("rp_start3_cyc", last_start, 14);
    chk("rp_n_stop", n_stop, 3);
    chk("rp_stop3_cyc", last_stop, 16);
    chk("rp_busy_first", first_busy, 1);
    chk("rp_busy_last", last_busy, 15);
    chk("rp_n_busy", n_busy, 15);
    chk("rp_n_pulse", n_pulse, 6);
    chk("rp_overlap", n_both, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/pulse_gen_16.md
# pulse_gen_16

Programmable single-shot pulse generator for the stopwatch/timer datapath. On a trigger it waits a programmed number of time-base ticks, then drives a pulse for a programmed number of ticks. It emits one-cycle `start` and `stop` strobes at the pulse edges, directly compatible with the start/stop inputs of the 16-bit timer blocks. It is the stimulus end of the start/stop interface: it produces timed start/stop events that the timer measures.

## Interface

- `BIT_SZ`, 16, width of the delay/width programming values and internal counter.

- `sysclk`  in  1  sole clock; all state changes on posedge.
- `sreset`  in  1  synchronous, active-high reset.
- `tick`  in  1  time-base enable, one `sysclk` wide; counters decrement only when high.
- `trigger`  in  1  request a pulse; accepted only in IDLE.
- `delay`  in  BIT_SZ  ticks from acceptance to pulse start; sampled on acceptance.
- `width`  in  BIT_SZ  ticks of pulse length beyond the mandatory first cycle; sampled on acceptance.
- `start`  out  1  one-cycle strobe, high in the first cycle of ACTIVE.
- `stop`  out  1  one-cycle strobe, high in the first cycle after ACTIVE ends.
- `pulse`  out  1  level, high exactly while in ACTIVE.
- `busy`  out  1  high in any state other than IDLE.

## Operation

- States (in shared enum): IDLE, DELAY, ACTIVE.
- **IDLE:** `trigger` high latches `width` into `width_r`. It loads `count <= delay` and moves to DELAY. `delay` is also latched into `delay_r` for repeat mode.
- **DELAY:**
  - If `count == 0`, go to ACTIVE and load `count <= width_r`.
  - Else, if `tick`, decrement `count`.
- **ACTIVE:**
  - If `count == 0`, go to IDLE.
  - Else, if `tick`, decrement `count`.
- The zero check takes priority over `tick` in the same cycle; that tick is not carried over.
- `trigger` while `busy` is ignored and is not queued.
- `delay` and `width` changes after acceptance have no effect.
- Counter arithmetic is unsigned BIT_SZ. It never decrements below 0, so it never wraps.
- Maximum values are 2^BIT_SZ−1 ticks each.
- All outputs are registered. There are no combinational input-to-output paths.

## Timing

- Reset value is 0 for all outputs. State is IDLE and `count`, `width_r` and `delay_r` are 0.
- `sreset` dominates every input. Reset mid-pulse drops `pulse` next cycle with no `stop` strobe.
- Trigger accepted at edge 0 gives DELAY in cycle 1.
- With `delay = 0`: `start` and `pulse` are high in cycle 2.
- With `tick` held high and delay D: `start` is high in cycle 2+D.
- With `tick` held high and width W: `pulse` is high for W+1 cycles. `stop` is high in the cycle `pulse` falls.
- `width = 0` gives a 1-cycle pulse.
- A `trigger` in the same cycle as `stop` is accepted (state is IDLE).
- `start` and `stop` are never high in the same cycle.

## Configuration

- Macro: `PULSE_GEN_REPEAT_EN`.
- **Defined:**
  - Adds input `halt` (1 bit).
  - When ACTIVE ends, if no halt is pending, the block reloads `count <= delay_r` and re-enters DELAY. `stop` strobes in that cycle and `busy` stays 1.
  - `halt` high in any busy cycle sets a sticky flag. The current pulse completes, then the block returns to IDLE. The flag clears on entering IDLE or on `sreset`.
- **Undefined:** `halt` port is absent and the block is single-shot only.

## Structure

- Package `pulse_gen_pkg` holds:
  - the state enum (IDLE/DELAY/ACTIVE);
  - default `BIT_SZ`.
- Sub-module `tick_down_counter`:
  - loadable BIT_SZ down-counter with `load`, `load_val`, `en` (tick) and `zero` output;
  - synchronous clear on `sreset`;
  - holds at 0.
- The FSM and output registers live in `pulse_gen_16`.

## Test plan

- Reset, then `delay=0`, `width=0`, `tick=1`, trigger at cycle 0 -> `start` at cycle 2, `pulse` high only in cycle 2, `stop` at cycle 3, `busy` cycles 1–2.
- `delay=3`, `width=4`, `tick` every 2nd cycle -> `pulse` rises after 3 counted ticks and stays high until 4 more ticks are counted. `start` and `stop` are each exactly one cycle.
- Second `trigger` during DELAY and during ACTIVE, with `delay`/`width` changed mid-pulse -> ignored; timing matches the original values.
- `sreset` asserted in the middle of ACTIVE with `width=100` -> next cycle all outputs 0 and no `stop` strobe. A trigger afterwards is accepted normally.
- `trigger` in the same cycle as `stop` -> accepted; `start` of the new pulse follows with `delay=0` 2 cycles later.
- With `PULSE_GEN_REPEAT_EN`, `delay=2`, `width=1`, `tick=1` -> continuous pulses with `busy` held. `halt` during the 3rd pulse -> that pulse completes, `stop` strobes, then IDLE with `busy=0`.
